// File: rtl/cube3.sv
// cube3: sequential integer cube, y_bo = a_bi^3, computed as two shift-add
// passes (a*a, then square*a), one operand bit per cycle.
// Optional build macro CUBE3_EARLY_EXIT_EN: each pass stops after the highest
// set bit of the operand instead of always running WIDTH cycles. Results are
// identical either way; only the busy time changes.
module cube3 #(
  parameter int WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_bi,
  output logic               busy_o,
  output logic [3*WIDTH-1:0] y_bo
);

  localparam int RW = 3 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, MUL1, MUL2, DONE} state_t;

  state_t          r_state;
  logic [WIDTH-1:0] r_a;
  logic [RW-1:0]   r_m;
  logic [RW-1:0]   r_acc;
  logic [CW-1:0]   r_ctr;
  logic            r_armed;

  logic [RW-1:0]   w_add;
  logic [RW-1:0]   w_acc_nxt;
  logic            w_last;
  logic            w_accept;

  // Partial product for the current operand bit and the running sum.
  assign w_add     = r_a[r_ctr] ? (r_m << r_ctr) : '0;
  assign w_acc_nxt = r_acc + w_add;

  // A pass ends on its final bit; with early exit, also once no higher
  // operand bits remain set (bits above ctr contribute nothing).
`ifdef CUBE3_EARLY_EXIT_EN
  assign w_last = (r_ctr == CW'(WIDTH - 1)) || (((r_a >> r_ctr) >> 1) == '0);
`else
  assign w_last = (r_ctr == CW'(WIDTH - 1));
`endif

  // A request is taken only when idle and start has been low since the last one.
  assign w_accept = start_i && !busy_o && r_armed;

  // Start re-arm: a held start runs once; it must drop before the next run.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)          r_armed <= 1'b1;
    else if (!start_i)   r_armed <= 1'b1;
    else if (w_accept)   r_armed <= 1'b0;
  end

  // Control FSM and datapath: accept, square pass, cube pass, publish.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_m     <= '0;
      r_acc   <= '0;
      r_ctr   <= '0;
      busy_o  <= 1'b0;
      y_bo    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a     <= a_bi;
            r_m     <= RW'(a_bi);
            r_acc   <= '0;
            r_ctr   <= '0;
            busy_o  <= 1'b1;
            r_state <= MUL1;
          end
        end
        MUL1: begin
          if (w_last) begin
            // Square becomes the multiplicand for the second pass.
            r_m     <= w_acc_nxt;
            r_acc   <= '0;
            r_ctr   <= '0;
            r_state <= MUL2;
          end else begin
            r_acc <= w_acc_nxt;
            r_ctr <= r_ctr + 1'b1;
          end
        end
        MUL2: begin
          r_acc <= w_acc_nxt;
          if (w_last) begin
            r_state <= DONE;
          end else begin
            r_ctr <= r_ctr + 1'b1;
          end
        end
        DONE: begin
          y_bo    <= r_acc;
          busy_o  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cube3.sv
// tb_cube3: directed stimulus with a scoreboard. The driver pushes the
// expected cube and busy length for each accepted request; a monitor pops
// and compares whenever busy_o falls.
module tb_cube3;
  localparam int W = 8;

  logic           clk_i = 1'b0;
  logic           rst_i = 1'b0;
  logic           start_i = 1'b0;
  logic [W-1:0]   a_bi = '0;
  logic           busy_o;
  logic [3*W-1:0] y_bo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3*W-1:0] y;
    int             len;
    int             a;
  } exp_t;
  exp_t sb_q[$];

  cube3 #(.WIDTH(W)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start_i(start_i),
    .a_bi   (a_bi),
    .busy_o (busy_o),
    .y_bo   (y_bo)
  );

  always #5 clk_i = ~clk_i;

  // Expected busy length for an operand.
  function automatic int exp_len(input int a);
`ifdef CUBE3_EARLY_EXIT_EN
    int ph;
    ph = 1;
    for (int b = 0; b < W; b++) if ((a >> b) & 1) ph = b + 1;
    return 2 * ph + 1;
`else
    return 2 * W + 1;
`endif
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: measure busy length, check result when busy falls.
  int  busy_cnt = 0;
  logic busy_prev = 1'b0;
  always @(negedge clk_i) begin
    if (!rst_i) begin
      busy_cnt  = 0;
      busy_prev = 1'b0;
    end else begin
      if (busy_o) busy_cnt++;
      if (busy_prev && !busy_o) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_completion: got y=%0d expected no completion", y_bo);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk($sformatf("y(a=%0d)", e.a), longint'(y_bo), longint'(e.y));
          chk($sformatf("busy_len(a=%0d)", e.a), busy_cnt, e.len);
        end
        busy_cnt = 0;
      end
      busy_prev = busy_o;
    end
  end

  // Wait (bounded) for busy_o to drop.
  task automatic wait_idle(input string name);
    for (int i = 0; i < 100; i++) begin
      if (!busy_o) return;
      @(posedge clk_i); #1;
    end
    checks++; errors++;
    $display("FAIL timeout_%s: busy_o still 1 expected 0", name);
  endtask

  // One-cycle start pulse; expectation pushed as the request is issued.
  task automatic do_op(input int a, input longint y);
    exp_t e;
    @(posedge clk_i); #1;
    start_i = 1'b1; a_bi = W'(a);
    e.y = (3*W)'(y); e.len = exp_len(a); e.a = a;
    sb_q.push_back(e);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    wait_idle($sformatf("a%0d", a));
  endtask

  initial begin
    exp_t e;
    #12;
    chk("reset_busy", busy_o, 0);
    chk("reset_y", y_bo, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;

    do_op(6, 216);
    do_op(255, 16581375);
    do_op(0, 0);

    // Start held high: exactly one run.
    @(posedge clk_i); #1;
    start_i = 1'b1; a_bi = 8'd2;
    e.y = 24'd8; e.len = exp_len(2); e.a = 2;
    sb_q.push_back(e);
    repeat (40) @(posedge clk_i);
    #1;
    chk("held_start_busy", busy_o, 0);
    start_i = 1'b0;
    @(posedge clk_i); #1;
    start_i = 1'b1; a_bi = 8'd3;
    e.y = 24'd27; e.len = exp_len(3); e.a = 3;
    sb_q.push_back(e);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    wait_idle("rearm");

    // Operand changes while busy must not affect the result.
    @(posedge clk_i); #1;
    start_i = 1'b1; a_bi = 8'd4;
    e.y = 24'd64; e.len = exp_len(4); e.a = 4;
    sb_q.push_back(e);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    a_bi = 8'd9;
    wait_idle("opchange");

    // Mid-operation reset: abort, outputs clear asynchronously, no result.
    @(posedge clk_i); #1;
    start_i = 1'b1; a_bi = 8'd5;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (6) @(posedge clk_i);
    #1;
    chk("pre_reset_busy", busy_o, 1);
    rst_i = 1'b0;
    #1;
    chk("async_reset_busy", busy_o, 0);
    chk("async_reset_y", y_bo, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    do_op(5, 125);

    // Early-exit operands (fixed latency unless the macro is defined).
    do_op(3, 27);
    do_op(0, 0);
    do_op(128, 2097152);
    do_op(1, 1);

    repeat (3) @(posedge clk_i);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded expected completion");
    $fatal(1, "watchdog");
  end
endmodule
